mux16_rr_scheduler: RTL and testbench
=====================================

Name: mux16_rr_scheduler

Overview:
Round-robin scheduler that shares the 16:1 bit mux (mux_16x1) between 16 requesters. It drives the mux select `s`, receives the mux output `y`, and presents the granted bit to a downstream consumer over a valid/ready handshake. Each requester holds the mux for a burst of up to HOLD accepted beats, and is acked once per beat. The block sits between the requesting sources and the serial consumer; the mux itself stays external.

Parameters:
N_REQ, 16, number of requesters; fixed to the mux width.
SEL_W, 4, select width (log2 N_REQ).
HOLD, 4, maximum accepted beats per grant (1..15).

Ports:
clk  in  1  rising-edge clock.
rst  in  1  synchronous, active-high reset.
req  in  16  per-requester request; level, held until served or withdrawn.
y  in  1  output of the external mux_16x1, which is driven with `s`.
out_ready  in  1  downstream accepts the current beat.
s  out  4  registered mux select (current or last grant).
out_bit  out  1  beat data; combinational copy of `y`.
out_valid  out  1  beat valid.
ack  out  16  one-hot pulse to the granted requester in each cycle a beat is accepted.
busy  out  1  high in state GRANT.
beat_cnt  out  4  accepted beats in the current grant.

Behaviour:
- Reset (clk edge with rst=1) sets:
  - state=IDLE, s=0, last=15 (so requester 0 has first priority), beat_cnt=0.
  - out_valid=0, ack=0, busy=0.
  - rst overrides everything, including a burst in progress; no ack is produced in the reset cycle.
- State IDLE:
  - out_valid=0, ack=0, busy=0, and s holds its last value.
  - If req != 0, select winner k = the first set bit searching last+1, last+2, ... modulo 16.
  - Next edge: s=k, last=k, beat_cnt=0, state=GRANT.
  - If req == 0, stay in IDLE.
- State GRANT:
  - busy=1.
  - out_valid = req[s]; out_bit = y; ack = (out_valid & out_ready) ? (1 << s) : 0.
  - A beat is accepted when out_valid & out_ready. On each accepted beat, beat_cnt increments.
  - Release (next state IDLE) occurs when either:
    - the beat accepted in this cycle makes beat_cnt+1 == HOLD, or
    - req[s]==0 (withdrawal: no ack, nothing accepted that cycle).
  - Otherwise stay in GRANT with s stable.
  - With out_ready=0, s, out_valid and beat_cnt are held and ack=0 (backpressure, no timeout).
- Latency:
  - req rising in IDLE at cycle t gives s valid and out_valid=1 at cycle t+1.
  - Exactly one IDLE bubble cycle separates consecutive grants.
  - With continuous ready, a full burst occupies HOLD cycles.
- Fairness:
  - Arbitration happens only in IDLE.
  - The just-served requester gets lowest priority next time.
  - A sole requester is re-granted after the bubble.
- Wrap-around:
  - The search wraps from 15 to 0.
  - last=15 with req=0x8000 grants 15 again.
- Simultaneous events:
  - A req change on the arbitration cycle is sampled as-is.
  - A withdrawal in the same cycle as the HOLD-th beat is a withdrawal; since out_valid=0, no ack.
- `s` is never changed in GRANT, so out_bit is glitch-consistent per beat.

Test Plan:
1. Reset: rst=1 for 2 cycles with req=16'hFFFF, out_ready=1 → s=0, out_valid=0, ack=0, busy=0, beat_cnt=0. After release, the first grant is s=0.
2. Single requester: mux d=16'b1111_1010_0001_0110, req=16'h0002, ready=1, HOLD=4 → s=1 from cycle 1, four beats with out_bit=1 and ack=16'h0002 each. Then one IDLE cycle (out_valid=0), then a re-grant with s=1.
3. Round robin: same d, req=16'h8011 held, ready=1 → grant order s=0,4,15,0. out_bit per grant is 0,1,1,0, with 4 beats each and a 1-cycle bubble between grants.
4. Backpressure: req=16'h0200, ready low for 3 cycles after beat 2 → s=9, out_valid=1, out_bit=1, ack=0 and beat_cnt=2 held for those cycles. Beats 3–4 are acked after ready returns.
5. Withdrawal: req=16'h0030, drop req[4] after 2 accepted beats → out_valid=0 and ack=0 that cycle, IDLE next, then s=5 granted with out_bit=0.
6. Reset mid-burst: assert rst during beat 2 of a grant to s=4 → next cycle IDLE with s=0, last=15, and no ack on the reset cycle.

Source files
------------

// File: rtl/mux16_rr_scheduler.sv
// mux16_rr_scheduler: round-robin owner of an external 16:1 bit mux.
// The block drives the mux select, takes the mux output back and presents
// it as a serial beat stream. Each requester keeps the mux for a burst of up
// to HOLD accepted beats.
//
// Handshake: a beat transfers in any cycle where out_valid && out_ready.
// out_valid only depends on the current grant and req[s], never on
// out_ready. While out_valid is high, s and out_bit stay stable until the
// beat is accepted or the requester withdraws its request.
//
// The FSM state is visible on `busy` (IDLE -> 0, GRANT -> 1).
module mux16_rr_scheduler #(
    parameter int N_REQ = 16,
    parameter int SEL_W = 4,
    parameter int HOLD  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             y,
    input  logic             out_ready,
    output logic [SEL_W-1:0] s,
    output logic             out_bit,
    output logic             out_valid,
    output logic [N_REQ-1:0] ack,
    output logic             busy,
    output logic [3:0]       beat_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [3:0] HOLD_CNT = 4'(HOLD);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] s_q, s_d;
    logic [SEL_W-1:0] last_q, last_d;
    logic [3:0]       beat_cnt_q, beat_cnt_d;

    logic             found;
    logic [SEL_W-1:0] winner;
    logic [SEL_W-1:0] idx;
    logic             accept;

    // Rotating priority search: the first set req bit after the last grant,
    // wrapping modulo N_REQ, so the previous owner is checked last.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = last_q + SEL_W'(i);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    // Next-state logic and handshake outputs. Reset suppresses the beat
    // outputs so that no ack can be issued in the reset cycle.
    always_comb begin
        state_d    = state_q;
        s_d        = s_q;
        last_d     = last_q;
        beat_cnt_d = beat_cnt_q;
        out_valid  = 1'b0;
        ack        = '0;
        busy       = 1'b0;
        accept     = 1'b0;

        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d    = GRANT;
                    s_d        = winner;
                    last_d     = winner;
                    beat_cnt_d = '0;
                end
            end
            GRANT: begin
                busy      = 1'b1;
                out_valid = req[s_q] & ~rst;
                accept    = out_valid & out_ready;
                if (accept) begin
                    ack = N_REQ'(1) << s_q;
                end
                if (!req[s_q]) begin
                    // Withdrawal: nothing accepted, give the mux up.
                    state_d = IDLE;
                end else if (accept) begin
                    beat_cnt_d = beat_cnt_q + 4'd1;
                    if (beat_cnt_q + 4'd1 == HOLD_CNT) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset leaves requester 0 with first priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            s_q        <= '0;
            last_q     <= '1;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            s_q        <= s_d;
            last_q     <= last_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign s        = s_q;
    assign out_bit  = y;
    assign beat_cnt = beat_cnt_q;

endmodule

// File: tb/tb_mux16_rr_scheduler.sv
// Directed bench for mux16_rr_scheduler with a behavioural 16:1 mux on s.
module tb_mux16_rr_scheduler;

    logic        clk;
    logic        rst;
    logic [15:0] req;
    logic        y;
    logic        out_ready;
    logic [3:0]  s;
    logic        out_bit;
    logic        out_valid;
    logic [15:0] ack;
    logic        busy;
    logic [3:0]  beat_cnt;

    logic [15:0] mux_d;

    int n_checks;
    int n_fail;

    mux16_rr_scheduler #(.N_REQ(16), .SEL_W(4), .HOLD(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .y         (y),
        .out_ready (out_ready),
        .s         (s),
        .out_bit   (out_bit),
        .out_valid (out_valid),
        .ack       (ack),
        .busy      (busy),
        .beat_cnt  (beat_cnt)
    );

    // External mux model.
    assign y = mux_d[s];

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run time exceeded, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock edge, then settle away from the edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    // Check one accepted beat in GRANT with out_ready high.
    task automatic check_beat(input string tag, input logic [3:0] exp_s,
                              input logic exp_bit, input logic [3:0] exp_cnt);
        settle();
        check({tag, " busy"},     busy,      1);
        check({tag, " s"},        s,         exp_s);
        check({tag, " valid"},    out_valid, 1);
        check({tag, " bit"},      out_bit,   exp_bit);
        check({tag, " ack"},      ack,       32'(16'h1 << exp_s));
        check({tag, " beat_cnt"}, beat_cnt,  exp_cnt);
    endtask

    task automatic check_idle(input string tag);
        settle();
        check({tag, " busy"},  busy,      0);
        check({tag, " valid"}, out_valid, 0);
        check({tag, " ack"},   ack,       0);
    endtask

    logic [3:0] rr_s   [4];
    logic       rr_bit [4];

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        mux_d     = 16'b1111_1010_0001_0110;
        req       = 16'hFFFF;
        out_ready = 1'b1;
        rst       = 1'b0;

        // 1. Reset with all requests high.
        rst = 1'b1;
        cycle();
        cycle();
        settle();
        check("rst s",        s,         0);
        check("rst valid",    out_valid, 0);
        check("rst ack",      ack,       0);
        check("rst busy",     busy,      0);
        check("rst beat_cnt", beat_cnt,  0);
        rst = 1'b0;
        cycle();
        check_beat("rst first", 4'd0, 1'b0, 4'd0);
        req = 16'h0000;
        cycle();
        check_idle("rst drop");

        // 2. Single requester: full burst, bubble, re-grant.
        req = 16'h0002;
        check_idle("single pre");
        cycle();
        for (int b = 0; b < 4; b++) begin
            check_beat("single", 4'd1, 1'b1, 4'(b));
            cycle();
        end
        check_idle("single bubble");
        cycle();
        check_beat("single regrant", 4'd1, 1'b1, 4'd0);
        req = 16'h0000;
        cycle();

        // 3. Round robin from reset priority.
        rr_s   = '{4'd0, 4'd4, 4'd15, 4'd0};
        rr_bit = '{1'b0, 1'b1, 1'b1, 1'b0};
        do_reset();
        req = 16'h8011;
        for (int g = 0; g < 4; g++) begin
            check_idle("rr bubble");
            cycle();
            for (int b = 0; b < 4; b++) begin
                check_beat("rr", rr_s[g], rr_bit[g], 4'(b));
                cycle();
            end
        end
        req = 16'h0000;
        cycle();

        // 4. Backpressure after two beats (last=0, so 9 wins).
        req = 16'h0200;
        cycle();
        for (int b = 0; b < 2; b++) begin
            check_beat("bp pre", 4'd9, 1'b1, 4'(b));
            cycle();
        end
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            settle();
            check("bp hold s",        s,         9);
            check("bp hold valid",    out_valid, 1);
            check("bp hold bit",      out_bit,   1);
            check("bp hold ack",      ack,       0);
            check("bp hold beat_cnt", beat_cnt,  2);
            check("bp hold busy",     busy,      1);
            cycle();
        end
        out_ready = 1'b1;
        for (int b = 2; b < 4; b++) begin
            check_beat("bp post", 4'd9, 1'b1, 4'(b));
            cycle();
        end
        check_idle("bp release");
        req = 16'h0000;
        cycle();

        // 5. Withdrawal after two beats (last=9, so 4 wins before 5).
        req = 16'h0030;
        cycle();
        for (int b = 0; b < 2; b++) begin
            check_beat("wd", 4'd4, 1'b1, 4'(b));
            cycle();
        end
        req = 16'h0020;
        settle();
        check("wd valid", out_valid, 0);
        check("wd ack",   ack,       0);
        check("wd busy",  busy,      1);
        cycle();
        check_idle("wd idle");
        cycle();
        check_beat("wd next", 4'd5, 1'b0, 4'd0);
        req = 16'h0000;
        cycle();

        // 6. Reset during the second beat of a grant to 4 (last=5).
        req = 16'h0010;
        cycle();
        check_beat("mid b0", 4'd4, 1'b1, 4'd0);
        cycle();
        rst = 1'b1;
        settle();
        check("mid rst ack",   ack,       0);
        check("mid rst valid", out_valid, 0);
        cycle();
        rst = 1'b0;
        check_idle("mid after");
        check("mid after s",        s,        0);
        check("mid after beat_cnt", beat_cnt, 0);
        req = 16'hFFFF;
        cycle();
        check_beat("mid last15", 4'd0, 1'b0, 4'd0);
        req = 16'h0000;
        cycle();

        // Wrap-around: last=15 with only requester 15 grants 15 twice.
        do_reset();
        req = 16'h8000;
        cycle();
        for (int b = 0; b < 4; b++) begin
            check_beat("wrap", 4'd15, 1'b1, 4'(b));
            cycle();
        end
        check_idle("wrap bubble");
        cycle();
        check_beat("wrap regrant", 4'd15, 1'b1, 4'd0);
        req = 16'h0000;
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
